// File: rtl/rx_deframer.sv
// rx_deframer: serial frame receiver rebuilding DATA_WIDTH-bit words with parity/stop checks and a valid/ready output buffer.
// Optional feature macro: RX_SYNC_EN adds a 2-flop input synchroniser (reset to 1) in front of the line sampler.
module rx_deframer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rx_in,
   input  logic                    parity_per_byte,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic [DATA_WIDTH/8-1:0] byte_perr,
   output logic                    parity_err,
   output logic                    frame_err,
   output logic                    data_valid,
   input  logic                    data_ready,
   output logic                    overrun,
   output logic                    rx_busy
);
   localparam int NB = DATA_WIDTH / 8;
   typedef enum logic [2:0] {WAIT_IDLE, IDLE, DATA, BYTE_PAR, FINAL_PAR, STOP} state_t;
   state_t          state;
   logic            rx_s;
   logic            mode;
   logic [6:0]      bit_cnt;
   logic [3:0]      byte_cnt;
   logic            byte_par;
   logic            word_par;
   logic [NB-1:0]   byte_perr_acc;
   logic            par_err_acc;
   logic [DATA_WIDTH-1:0] sh;
`ifdef RX_SYNC_EN
   logic [1:0] sync;
   // two-flop synchroniser, reset high so a reset never looks like a start bit
   always_ff @(posedge clk)
      if (rst) sync <= 2'b11;
      else sync <= {sync[0], rx_in};
   assign rx_s = sync[1];
`else
   assign rx_s = rx_in;
`endif
   // frame FSM, accumulators and the single-entry output buffer
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= WAIT_IDLE;
         mode          <= 1'b0;
         bit_cnt       <= '0;
         byte_cnt      <= '0;
         byte_par      <= 1'b0;
         word_par      <= 1'b0;
         byte_perr_acc <= '0;
         par_err_acc   <= 1'b0;
         sh            <= '0;
         data_out      <= '0;
         byte_perr     <= '0;
         parity_err    <= 1'b0;
         frame_err     <= 1'b0;
         data_valid    <= 1'b0;
         overrun       <= 1'b0;
         rx_busy       <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (data_valid && data_ready) data_valid <= 1'b0;
         case (state)
            WAIT_IDLE: begin
               if (rx_s) state <= IDLE;
               rx_busy <= !rx_s;
            end
            IDLE: begin
               if (!rx_s) begin
                  state         <= DATA;
                  mode          <= parity_per_byte;
                  bit_cnt       <= '0;
                  byte_cnt      <= '0;
                  byte_par      <= 1'b0;
                  word_par      <= 1'b0;
                  byte_perr_acc <= '0;
                  par_err_acc   <= 1'b0;
               end
               rx_busy <= !rx_s;
            end
            DATA: begin
               sh       <= {rx_s, sh[DATA_WIDTH-1:1]};
               bit_cnt  <= bit_cnt + 7'd1;
               byte_par <= byte_par ^ rx_s;
               word_par <= word_par ^ rx_s;
               if (mode && bit_cnt[2:0] == 3'd7) state <= BYTE_PAR;
               else if (!mode && bit_cnt == 7'(DATA_WIDTH - 1)) state <= FINAL_PAR;
               rx_busy  <= 1'b1;
            end
            BYTE_PAR: begin
               byte_perr_acc <= byte_perr_acc | (NB'(rx_s ^ byte_par) << byte_cnt);
               byte_par      <= 1'b0;
               byte_cnt      <= byte_cnt + 4'd1;
               state         <= (byte_cnt == 4'(NB - 1)) ? FINAL_PAR : DATA;
               rx_busy       <= 1'b1;
            end
            FINAL_PAR: begin
               par_err_acc <= rx_s ^ word_par;
               state       <= STOP;
               rx_busy     <= 1'b1;
            end
            STOP: begin
               if (!data_valid || data_ready) begin
                  data_out   <= sh;
                  byte_perr  <= byte_perr_acc;
                  parity_err <= par_err_acc;
                  frame_err  <= ~rx_s;
                  data_valid <= 1'b1;
               end else begin
                  overrun <= 1'b1;
               end
               state   <= rx_s ? IDLE : WAIT_IDLE;
               rx_busy <= !rx_s;
            end
            default: begin
               state   <= WAIT_IDLE;
               rx_busy <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rx_deframer.sv
// tb_rx_deframer: directed self-checking bench for rx_deframer (DATA_WIDTH=16, no input synchroniser).
module tb_rx_deframer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_in = 1'b1;
   logic        parity_per_byte = 1'b0;
   logic        data_ready = 1'b1;
   logic [15:0] data_out;
   logic [1:0]  byte_perr;
   logic        parity_err, frame_err, data_valid, overrun, rx_busy;
   int checks = 0;
   int failures = 0;

   rx_deframer #(.DATA_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .rx_in(rx_in), .parity_per_byte(parity_per_byte),
      .data_out(data_out), .byte_perr(byte_perr), .parity_err(parity_err),
      .frame_err(frame_err), .data_valid(data_valid), .data_ready(data_ready),
      .overrun(overrun), .rx_busy(rx_busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      rx_in = b;
      tick();
   endtask

   // start, data LSB-first with optional per-byte parity, final parity, stop; mode input is toggled mid-frame
   task automatic send_frame(input logic [15:0] w, input logic pb, input logic inv, input logic stop, input logic rdy);
      logic [7:0] b;
      parity_per_byte = pb;
      send_bit(1'b0);
      parity_per_byte = !pb;
      for (int k = 0; k < 2; k++) begin
         b = w[8*k +: 8];
         for (int i = 0; i < 8; i++) send_bit(b[i]);
         if (pb) send_bit((^b) ^ inv);
      end
      send_bit((^w) ^ inv);
      data_ready = rdy;
      send_bit(stop);
      if (stop) rx_in = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; rx_in = 1'b1; data_ready = 1'b1;
      tick(); tick();
      checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", data_valid); end
      checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", rx_busy); end
      checks++; if (data_out !== 16'h0000) begin failures++; $display("FAIL rst_data got=%h exp=0000", data_out); end
      checks++; if ({overrun, frame_err, parity_err, byte_perr} !== 5'b0) begin failures++; $display("FAIL rst_flags got=%b exp=00000", {overrun, frame_err, parity_err, byte_perr}); end
      rst = 1'b0;
      tick(); tick();
      checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", rx_busy); end
   endtask

   task automatic test_whole_word();
      send_frame(16'hA5C3, 1'b0, 1'b0, 1'b1, 1'b1);
      checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL ww_valid got=%b exp=1", data_valid); end
      checks++; if (data_out !== 16'hA5C3) begin failures++; $display("FAIL ww_data got=%h exp=a5c3", data_out); end
      checks++; if ({frame_err, parity_err, byte_perr} !== 4'b0) begin failures++; $display("FAIL ww_flags got=%b exp=0000", {frame_err, parity_err, byte_perr}); end
      tick();
      checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL ww_drain got=%b exp=0", data_valid); end
   endtask

   task automatic test_per_byte();
      send_frame(16'h8001, 1'b1, 1'b0, 1'b1, 1'b1);
      checks++; if (data_out !== 16'h8001) begin failures++; $display("FAIL pb_data got=%h exp=8001", data_out); end
      checks++; if ({parity_err, byte_perr} !== 3'b000) begin failures++; $display("FAIL pb_flags got=%b exp=000", {parity_err, byte_perr}); end
      send_frame(16'h8001, 1'b1, 1'b1, 1'b1, 1'b1);
      checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL pbi_valid got=%b exp=1", data_valid); end
      checks++; if (data_out !== 16'h8001) begin failures++; $display("FAIL pbi_data got=%h exp=8001", data_out); end
      checks++; if (byte_perr !== 2'b11) begin failures++; $display("FAIL pbi_byte_perr got=%b exp=11", byte_perr); end
      checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL pbi_parity_err got=%b exp=1", parity_err); end
      tick();
   endtask

   task automatic test_frame_err();
      send_frame(16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++; if ({data_valid, frame_err} !== 2'b11) begin failures++; $display("FAIL fe_flag got=%b exp=11", {data_valid, frame_err}); end
      checks++; if (data_out !== 16'h5A5A) begin failures++; $display("FAIL fe_data got=%h exp=5a5a", data_out); end
      repeat (5) tick();
      checks++; if ({data_valid, rx_busy} !== 2'b01) begin failures++; $display("FAIL fe_wait got=%b exp=01", {data_valid, rx_busy}); end
      send_bit(1'b1);
      checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL fe_idle got=%b exp=0", rx_busy); end
      send_frame(16'h1234, 1'b0, 1'b0, 1'b1, 1'b1);
      checks++; if (data_out !== 16'h1234) begin failures++; $display("FAIL fe_next_data got=%h exp=1234", data_out); end
      checks++; if ({data_valid, frame_err, parity_err} !== 3'b100) begin failures++; $display("FAIL fe_next_flags got=%b exp=100", {data_valid, frame_err, parity_err}); end
      tick();
   endtask

   task automatic test_overrun();
      send_frame(16'h1111, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++; if ({data_valid, overrun} !== 2'b10) begin failures++; $display("FAIL ov_first got=%b exp=10", {data_valid, overrun}); end
      send_frame(16'h2222, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ov_pulse got=%b exp=1", overrun); end
      checks++; if (data_out !== 16'h1111) begin failures++; $display("FAIL ov_hold got=%h exp=1111", data_out); end
      tick();
      checks++; if ({data_valid, overrun} !== 2'b10) begin failures++; $display("FAIL ov_pulse_end got=%b exp=10", {data_valid, overrun}); end
      send_frame(16'h3333, 1'b0, 1'b0, 1'b1, 1'b1);
      checks++; if (data_out !== 16'h3333) begin failures++; $display("FAIL ov_swap_data got=%h exp=3333", data_out); end
      checks++; if ({data_valid, overrun} !== 2'b10) begin failures++; $display("FAIL ov_swap_flags got=%b exp=10", {data_valid, overrun}); end
      tick();
      checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL ov_drain got=%b exp=0", data_valid); end
   endtask

   task automatic test_reset_mid();
      int seen;
      send_frame(16'h00FF, 1'b0, 1'b0, 1'b1, 1'b0);
      send_bit(1'b0);
      repeat (5) send_bit(1'b1);
      rst = 1'b1;
      tick();
      checks++; if ({data_valid, rx_busy} !== 2'b00) begin failures++; $display("FAIL rm_flags got=%b exp=00", {data_valid, rx_busy}); end
      checks++; if (data_out !== 16'h0000) begin failures++; $display("FAIL rm_data got=%h exp=0000", data_out); end
      rst = 1'b0; rx_in = 1'b0; data_ready = 1'b1;
      seen = 0;
      repeat (25) begin
         tick();
         if (data_valid) seen++;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL rm_low_line got=%0d exp=0", seen); end
      send_bit(1'b1);
      send_frame(16'hBEEF, 1'b1, 1'b0, 1'b1, 1'b1);
      checks++; if (data_out !== 16'hBEEF) begin failures++; $display("FAIL rm_next_data got=%h exp=beef", data_out); end
      checks++; if ({data_valid, frame_err, parity_err, byte_perr} !== 5'b10000) begin failures++; $display("FAIL rm_next_flags got=%b exp=10000", {data_valid, frame_err, parity_err, byte_perr}); end
      tick();
   endtask

   initial begin
      test_reset();
      test_whole_word();
      test_per_byte();
      test_frame_err();
      test_overrun();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
